// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path: capture-mode encodings,
// the internal format enum, the frame FSM state enum, the byte-order
// constant and the gray-to-RGB565 expansion helper.
package cam_capture_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PIX_W  = 16;

  // capture_mode encodings; 11 behaves exactly like 00
  localparam logic [1:0] MODE_RGB_FULL = 2'b00;
  localparam logic [1:0] MODE_RGB_DEC  = 2'b01;
  localparam logic [1:0] MODE_GRAY     = 2'b10;
  localparam logic [1:0] MODE_RGB_ALT  = 2'b11;

  // First byte of a pair lands in dout[15:8]
  localparam bit BYTE0_IS_MSB = 1'b1;

  typedef enum logic [1:0] {
    WAIT_VS_HIGH = 2'd0,
    WAIT_VS_LOW  = 2'd1,
    CAPTURE      = 2'd2,
    SKIP         = 2'd3
  } cap_state_e;

  typedef enum logic [1:0] {
    FMT_RGB     = 2'd0,
    FMT_RGB_DEC = 2'd1,
    FMT_GRAY    = 2'd2
  } cap_fmt_e;

  function automatic cap_fmt_e decode_mode(input logic [1:0] mode);
    cap_fmt_e fmt;
    case (mode)
      MODE_RGB_FULL: fmt = FMT_RGB;
      MODE_RGB_DEC:  fmt = FMT_RGB_DEC;
      MODE_GRAY:     fmt = FMT_GRAY;
      MODE_RGB_ALT:  fmt = FMT_RGB;
      default:       fmt = FMT_RGB;
    endcase
    return fmt;
  endfunction

  // Replicate luma into all three RGB565 channels
  function automatic logic [PIX_W-1:0] gray_to_rgb565(input logic [BYTE_W-1:0] y);
    return {y[7:3], y[7:2], y[7:3]};
  endfunction

endpackage

// File: rtl/cam_byte_pairer.sv
// Pairs consecutive camera bytes into one 16-bit pixel and applies the
// output format (RGB565 pass-through or Y -> gray RGB565).
// Ports: clk, reset (sync, active-high); clear drops any half-formed pair;
// byte_valid/din present one byte; gray selects Y mode; pix_valid_c/pix_c
// give the combinational pixel in the cycle the second byte is presented.
module cam_byte_pairer
  import cam_capture_pkg::*;
#(
  parameter int unsigned DIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic             gray,
  input  logic [DIN_W-1:0] din,
  output logic             pix_valid_c,
  output logic [PIX_W-1:0] pix_c
);

  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] byte0_q, byte0_d;
  logic [BYTE_W-1:0] byte_in;

  assign byte_in = din[BYTE_W-1:0];

  // Pair tracking; clear discards a dangling first byte
  always_comb begin
    phase_d     = phase_q;
    byte0_d     = byte0_q;
    pix_valid_c = 1'b0;
    pix_c       = '0;
    if (clear) begin
      phase_d = 1'b0;
    end else if (byte_valid) begin
      if (!phase_q) begin
        byte0_d = byte_in;
        phase_d = 1'b1;
      end else begin
        phase_d     = 1'b0;
        pix_valid_c = 1'b1;
        if (gray) begin
          pix_c = gray_to_rgb565(byte0_q);
        end else if (BYTE0_IS_MSB) begin
          pix_c = {byte0_q, byte_in};
        end else begin
          pix_c = {byte_in, byte0_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      byte0_q <= '0;
    end else begin
      phase_q <= phase_d;
      byte0_q <= byte0_d;
    end
  end

endmodule

// File: rtl/pixel_capture_engine.sv
// Camera frame capture: registers the sensor interface, tracks frames with a
// vsync-driven FSM, counts rows/columns and emits frame-buffer writes.
// Ports: clk, reset (sync, active-high); vsync/href/din camera bus;
// capture_enable/capture_mode sampled at frame start; addr/dout/we write
// port (registered, 2 cycles after byte1 at the pins); frame_done pulse,
// frame_count and sticky line_err status.
module pixel_capture_engine
  import cam_capture_pkg::*;
#(
  parameter int unsigned DIN_W  = 8,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [DIN_W-1:0]  din,
  input  logic              capture_enable,
  input  logic [1:0]        capture_mode,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              line_err
);

  localparam int unsigned COL_W      = $clog2(H_RES + 1);
  localparam int unsigned ROW_W      = $clog2(V_RES + 1);
  localparam int unsigned BCNT_W     = $clog2(2 * H_RES + 2);
  localparam int unsigned LINE_BYTES = 2 * H_RES;

  logic               vsync_q, href_q, href_prev_q;
  logic [DIN_W-1:0]   din_q;
  cap_state_e         state_q, state_d;
  cap_fmt_e           fmt_q, fmt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, waddr;
  logic [15:0]        dout_q, dout_d;
  logic               we_q, we_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               line_err_q, line_err_d;
  logic               frame_start, byte_valid, line_end, in_range;
  logic               pix_valid;
  logic [PIX_W-1:0]   pix;

  // Bytes only count while capturing and before vsync rises
  assign byte_valid = href_q && !vsync_q && (state_q == CAPTURE);
  // Line ends on href fall, or when vsync rises with href still high
  assign line_end   = (state_q == CAPTURE) && href_prev_q && (!href_q || vsync_q);

  cam_byte_pairer #(.DIN_W(DIN_W)) u_pairer (
    .clk         (clk),
    .reset       (reset),
    .clear       (frame_start || line_end),
    .byte_valid  (byte_valid),
    .gray        (fmt_q == FMT_GRAY),
    .din         (din_q),
    .pix_valid_c (pix_valid),
    .pix_c       (pix)
  );

  // Frame FSM; WAIT_VS_HIGH guarantees a full blanking interval after reset
  always_comb begin
    state_d       = state_q;
    fmt_d         = fmt_q;
    frame_start   = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      WAIT_VS_HIGH: if (vsync_q) state_d = WAIT_VS_LOW;
      WAIT_VS_LOW: begin
        // vsync_q was high on entry, so low here is the falling edge
        if (!vsync_q) begin
          fmt_d = decode_mode(capture_mode);
          if (capture_enable) begin
            state_d     = CAPTURE;
            frame_start = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end
      CAPTURE: begin
        if (vsync_q) begin
          state_d       = WAIT_VS_LOW;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      SKIP: if (vsync_q) state_d = WAIT_VS_LOW;
      default: state_d = WAIT_VS_HIGH;
    endcase
  end

  // Row/column tracking, address generation and line-length check
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    bcnt_d     = bcnt_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    we_d       = 1'b0;
    line_err_d = line_err_q;
    if (fmt_q == FMT_RGB_DEC) begin
      waddr = ADDR_W'(row_q >> 1) * ADDR_W'(H_RES / 2) + ADDR_W'(col_q >> 1);
    end else begin
      waddr = ADDR_W'(row_q) * ADDR_W'(H_RES) + ADDR_W'(col_q);
    end
    in_range = (row_q < ROW_W'(V_RES)) && (col_q < COL_W'(H_RES)) &&
               ((fmt_q != FMT_RGB_DEC) || (!row_q[0] && !col_q[0]));
    if (frame_start) begin
      row_d      = '0;
      col_d      = '0;
      bcnt_d     = '0;
      line_err_d = 1'b0;
    end else if (line_end) begin
      col_d  = '0;
      bcnt_d = '0;
      if ((col_q != '0) && (row_q != ROW_W'(V_RES))) row_d = row_q + ROW_W'(1);
      if (bcnt_q != BCNT_W'(LINE_BYTES)) line_err_d = 1'b1;
    end else begin
      if (byte_valid && (bcnt_q != BCNT_W'(LINE_BYTES + 1))) bcnt_d = bcnt_q + BCNT_W'(1);
      if (pix_valid) begin
        // Counters saturate so an over-long line or frame never wraps
        if (col_q != COL_W'(H_RES)) col_d = col_q + COL_W'(1);
        if (in_range) begin
          we_d   = 1'b1;
          addr_d = waddr;
          dout_d = pix;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      href_prev_q   <= 1'b0;
      din_q         <= '0;
      state_q       <= WAIT_VS_HIGH;
      fmt_q         <= FMT_RGB;
      row_q         <= '0;
      col_q         <= '0;
      bcnt_q        <= '0;
      addr_q        <= '0;
      dout_q        <= '0;
      we_q          <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      line_err_q    <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      href_q        <= href;
      href_prev_q   <= href_q;
      din_q         <= din;
      state_q       <= state_d;
      fmt_q         <= fmt_d;
      row_q         <= row_d;
      col_q         <= col_d;
      bcnt_q        <= bcnt_d;
      addr_q        <= addr_d;
      dout_q        <= dout_d;
      we_q          <= we_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      line_err_q    <= line_err_d;
    end
  end

  assign addr        = addr_q;
  assign dout        = dout_q;
  assign we          = we_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_pixel_capture_engine.sv
// Bench for pixel_capture_engine on a reduced 8x6 sensor geometry.
module tb_pixel_capture_engine;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          href;
  logic [7:0]    din;
  logic          capture_enable;
  logic [1:0]    capture_mode;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic          we;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          line_err;

  pixel_capture_engine #(.DIN_W(8), .H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .vsync          (vsync),
    .href           (href),
    .din            (din),
    .capture_enable (capture_enable),
    .capture_mode   (capture_mode),
    .addr           (addr),
    .dout           (dout),
    .we             (we),
    .frame_done     (frame_done),
    .frame_count    (frame_count),
    .line_err       (line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          a;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/pulse recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (we === 1'b1) wq.push_back('{int'(addr), dout, cyc});
    if (frame_done === 1'b1) done_cnt = done_cnt + 1;
  end

  int total = 0;
  int bad   = 0;
  int byte1_cyc = 0;
  int rsnap_w = 0;
  int rsnap_d = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_val(input int pat, input logic [7:0] c, input int k, input int b);
    if (pat == 0) return 8'(k);
    return (b % 2 == 0) ? c : ~c;
  endfunction

  // Expected pixel of the incrementing-byte frame at write address a
  function automatic logic [15:0] incr_pix(input int a, input logic [1:0] mode);
    int row, col, p;
    if (mode == 2'b01) begin
      row = 2 * (a / (H / 2));
      col = 2 * (a % (H / 2));
    end else begin
      row = a / H;
      col = a % H;
    end
    p = row * H + col;
    return {8'(2 * p), 8'(2 * p + 1)};
  endfunction

  // One frame: blanking, V lines of href, then vsync high again
  task automatic drive_frame(input int pat, input logic [7:0] cval, input int short_row,
                             input int short_len, input int rst_row, input bit en_mid,
                             input bit vs_in_href);
    int k;
    k = 0;
    vsync = 1'b1; href = 1'b0; repeat (3) step();
    vsync = 1'b0; repeat (3) step();
    for (int r = 0; r < V; r++) begin
      int nb;
      nb = (r == short_row) ? short_len : 2 * H;
      if (en_mid && r == 2) capture_enable = 1'b1;
      for (int b = 0; b < nb; b++) begin
        href = 1'b1;
        din  = byte_val(pat, cval, k, b);
        if (r == rst_row && b == 4) begin
          reset   = 1'b1;
          rsnap_w = wq.size();
          rsnap_d = done_cnt;
        end else begin
          reset = 1'b0;
        end
        if (r == 0 && b == 1) byte1_cyc = cyc;
        k++;
        step();
      end
      reset = 1'b0;
      if (vs_in_href && r == V - 1) begin
        vsync = 1'b1;
        repeat (2) step();
      end
      href = 1'b0;
      repeat (3) step();
    end
    vsync = 1'b1;
    repeat (4) step();
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        en;
    logic        en_mid;
    int          pat;
    logic [7:0]  c;
    int          exp_writes;
    int          exp_done;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ws, ds, nw, exp_fc, cnt, idx;
    logic [31:0] found;

    vecs[0] = '{2'b00, 1'b1, 1'b0, 0, 8'h00, 48, 1, 16'h0000};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 0, 8'h00, 12, 1, 16'h0000};
    vecs[2] = '{2'b10, 1'b1, 1'b0, 1, 8'hFF, 48, 1, 16'hFFFF};
    vecs[3] = '{2'b10, 1'b1, 1'b0, 1, 8'h80, 48, 1, 16'h8410};
    vecs[4] = '{2'b11, 1'b1, 1'b0, 1, 8'h3C, 48, 1, 16'h3CC3};
    vecs[5] = '{2'b00, 1'b0, 1'b1, 0, 8'h00, 0,  0, 16'h0000};
    vecs[6] = '{2'b01, 1'b1, 1'b0, 1, 8'hA5, 12, 1, 16'hA55A};

    reset = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
    capture_enable = 1'b0; capture_mode = 2'b00;
    repeat (3) step();
    chk("rst addr", 32'(addr), 0);
    chk("rst dout", 32'(dout), 0);
    chk("rst we", 32'(we), 0);
    chk("rst frame_done", 32'(frame_done), 0);
    chk("rst frame_count", 32'(frame_count), 0);
    chk("rst line_err", 32'(line_err), 0);
    reset = 1'b0;
    step();

    exp_fc = 0;
    foreach (vecs[vi]) begin
      capture_mode   = vecs[vi].mode;
      capture_enable = vecs[vi].en;
      ws = wq.size(); ds = done_cnt;
      drive_frame(vecs[vi].pat, vecs[vi].c, -1, 0, -1, vecs[vi].en_mid, 1'b0);
      nw = wq.size() - ws;
      exp_fc += vecs[vi].exp_done;
      chk($sformatf("v%0d writes", vi), 32'(nw), 32'(vecs[vi].exp_writes));
      chk($sformatf("v%0d frame_done", vi), 32'(done_cnt - ds), 32'(vecs[vi].exp_done));
      chk($sformatf("v%0d frame_count", vi), 32'(frame_count), 32'(exp_fc));
      chk($sformatf("v%0d line_err", vi), 32'(line_err), 0);
      for (int i = 0; i < nw; i++) begin
        chk($sformatf("v%0d addr[%0d]", vi, i), 32'(wq[ws + i].a), 32'(i));
        chk($sformatf("v%0d dout[%0d]", vi, i), 32'(wq[ws + i].d),
            32'((vecs[vi].pat == 0) ? incr_pix(i, vecs[vi].mode) : vecs[vi].exp_d));
      end
      if (vi == 0 && nw > 0)
        chk("latency byte1->we", 32'(wq[ws].c - byte1_cyc), 2);
    end

    // Short line: row 2 carries 15 bytes, dangling byte dropped
    capture_mode = 2'b00; capture_enable = 1'b1;
    ws = wq.size(); ds = done_cnt;
    drive_frame(0, 8'h00, 2, 2 * H - 1, -1, 1'b0, 1'b0);
    exp_fc++;
    nw = wq.size() - ws;
    cnt = 0; found = 32'hFFFF_FFFF;
    for (int i = 0; i < nw; i++) begin
      idx = wq[ws + i].a;
      if (idx >= 2 * H && idx < 3 * H) cnt++;
      if (idx == 3 * H) found = 32'(wq[ws + i].d);
    end
    chk("short writes", 32'(nw), 47);
    chk("short row writes", 32'(cnt), 7);
    chk("short next row pixel", found, 32'h2F30);
    chk("short line_err", 32'(line_err), 1);
    chk("short frame_done", 32'(done_cnt - ds), 1);
    ws = wq.size();
    drive_frame(1, 8'h11, -1, 0, -1, 1'b0, 1'b0);
    exp_fc++;
    chk("clear line_err", 32'(line_err), 0);
    chk("clear writes", 32'(wq.size() - ws), 48);

    // vsync rises while href is still high on a 10-byte last line
    ws = wq.size(); ds = done_cnt;
    drive_frame(0, 8'h00, V - 1, 10, -1, 1'b0, 1'b1);
    exp_fc++;
    chk("vs-href writes", 32'(wq.size() - ws), 45);
    chk("vs-href frame_done", 32'(done_cnt - ds), 1);
    chk("vs-href line_err", 32'(line_err), 1);
    chk("vs-href frame_count", 32'(frame_count), 32'(exp_fc));

    // Reset asserted mid-line in row 3
    drive_frame(0, 8'h00, -1, 0, 3, 1'b0, 1'b0);
    chk("mid-rst writes after", 32'(wq.size() - rsnap_w), 0);
    chk("mid-rst frame_done", 32'(done_cnt - rsnap_d), 0);
    chk("mid-rst frame_count", 32'(frame_count), 0);
    chk("mid-rst line_err", 32'(line_err), 0);
    ws = wq.size(); ds = done_cnt;
    drive_frame(0, 8'h00, -1, 0, -1, 1'b0, 1'b0);
    nw = wq.size() - ws;
    chk("post-rst writes", 32'(nw), 48);
    chk("post-rst first addr", (nw > 0) ? 32'(wq[ws].a) : 32'hFFFF_FFFF, 0);
    chk("post-rst first dout", (nw > 0) ? 32'(wq[ws].d) : 32'hFFFF_FFFF, 32'h0001);
    chk("post-rst last addr", (nw > 0) ? 32'(wq[$].a) : 32'hFFFF_FFFF, 47);
    chk("post-rst frame_done", 32'(done_cnt - ds), 1);
    chk("post-rst frame_count", 32'(frame_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
